// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, cause codes and default vectors
package pipe_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_TAKE   = 3'd2;
    localparam state_t ST_KERNEL = 3'd3;
    localparam state_t ST_RETURN = 3'd4;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_IRQ  = 2'b01;
    localparam logic [1:0] CAUSE_EXC  = 2'b10;

    localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-flop irq synchroniser with rising-edge pulse
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/irq_exc_ctrl.sv
// rtl/irq_exc_ctrl.sv - irq/exception redirect sequencer; IRQ_MASK_EN adds irq_mask input
module irq_exc_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR  = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
`ifdef IRQ_MASK_EN
    input  logic        irq_mask,
`endif
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] id_pc,
    input  logic        id_valid,
    input  logic        stall_in,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        kmode,
    output logic        err_sticky
);

    state_t state_q, state_d;
    logic   irq_pending;
    logic   take_irq_q;
    logic   irq_rise;
    logic   irq_masked;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .irq_rise (irq_rise)
    );

`ifdef IRQ_MASK_EN
    assign irq_masked = irq_mask;
`else
    assign irq_masked = 1'b0;
`endif

    // The edge pulse itself counts as pending so an irq can be taken the cycle it is detected.
    logic irq_avail, exc_sel, evt_any, slot_ok, enter_take;
    assign irq_avail  = (irq_pending | irq_rise) & ~irq_masked;
    assign exc_sel    = exc_req & id_valid;
    assign evt_any    = exc_sel | irq_avail;
    assign slot_ok    = id_valid & ~stall_in;
    assign enter_take = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) && evt_any && slot_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (evt_any) state_d = slot_ok ? ST_TAKE : ST_WAIT;
                else         state_d = ST_IDLE;
            end
            ST_TAKE:   state_d = ST_KERNEL;
            ST_KERNEL: if (eret && slot_ok) state_d = ST_RETURN;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            irq_pending <= 1'b0;
            take_irq_q  <= 1'b0;
            epc         <= '0;
            cause       <= CAUSE_NONE;
            kmode       <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            state_q <= state_d;

            // A fresh edge wins over the clear so it is never lost during TAKE.
            if (irq_rise)
                irq_pending <= 1'b1;
            else if (state_q == ST_TAKE && take_irq_q)
                irq_pending <= 1'b0;

            if (enter_take)
                take_irq_q <= ~exc_sel;

            case (state_q)
                ST_TAKE: begin
                    epc   <= id_pc;
                    cause <= take_irq_q ? CAUSE_IRQ : CAUSE_EXC;
                    kmode <= 1'b1;
                end
                ST_KERNEL: begin
                    if (exc_sel) err_sticky <= 1'b1;
                end
                ST_RETURN: begin
                    kmode <= 1'b0;
                    cause <= CAUSE_NONE;
                end
                default: ;
            endcase
        end
    end

    // ERET retires harmlessly, so RETURN leaves ID/EX alone.
    always_comb begin
        pc_redirect = 1'b0;
        pc_target   = '0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state_q)
            ST_TAKE: begin
                pc_redirect = 1'b1;
                pc_target   = take_irq_q ? IRQ_VECTOR : EXC_VECTOR;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            ST_RETURN: begin
                pc_redirect = 1'b1;
                pc_target   = epc;
                flush_if_id = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb/tb_irq_exc_ctrl.sv - scoreboard bench for irq_exc_ctrl
module tb_irq_exc_ctrl;

    localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset, irq, exc_req, eret, id_valid, stall_in;
    logic [31:0] id_pc;
`ifdef IRQ_MASK_EN
    logic        irq_mask;
`endif
    logic        pc_redirect, flush_if_id, flush_id_ex, kmode, err_sticky;
    logic [31:0] pc_target, epc;
    logic [1:0]  cause;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] target;
        logic        fl_id_ex;
        logic [31:0] epc_after;
        logic [1:0]  cause_after;
        logic        kmode_after;
    } exp_t;

    exp_t exp_q[$];

    irq_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
`ifdef IRQ_MASK_EN
        .irq_mask    (irq_mask),
`endif
        .exc_req     (exc_req),
        .eret        (eret),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .stall_in    (stall_in),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .epc         (epc),
        .cause       (cause),
        .kmode       (kmode),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_redirect(input string tag, input int exp_edges);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < exp_edges + 8) begin
            step(1);
            n++;
            if (pc_redirect) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        else       check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    endtask

    task automatic push(input logic [31:0] t, input logic f, input logic [31:0] e,
                        input logic [1:0] c, input logic k);
        exp_t x;
        x.target = t; x.fl_id_ex = f; x.epc_after = e; x.cause_after = c; x.kmode_after = k;
        exp_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_redirect"}, 32'(pc_redirect), 32'd0);
        check({tag, "_target"},   pc_target,        32'd0);
        check({tag, "_flushes"},  32'({flush_if_id, flush_id_ex}), 32'd0);
        check({tag, "_epc"},      epc,              32'd0);
        check({tag, "_cause"},    32'(cause),       32'd0);
        check({tag, "_kmode"},    32'(kmode),       32'd0);
        check({tag, "_sticky"},   32'(err_sticky),  32'd0);
    endtask

    // Scoreboard monitor: pops an expectation on every redirect, then checks registered results.
    exp_t post_exp;
    bit   post_pending = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            post_pending = 1'b0;
        end else begin
            if (post_pending) begin
                check("post_epc",   epc,          post_exp.epc_after);
                check("post_cause", 32'(cause),   32'(post_exp.cause_after));
                check("post_kmode", 32'(kmode),   32'(post_exp.kmode_after));
                post_pending = 1'b0;
            end
            if (pc_redirect) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_redirect", 32'(pc_redirect), 32'd0);
                end else begin
                    post_exp = exp_q.pop_front();
                    check("redir_target",   pc_target,          post_exp.target);
                    check("redir_flush_if", 32'(flush_if_id),   32'd1);
                    check("redir_flush_ex", 32'(flush_id_ex),   32'(post_exp.fl_id_ex));
                    post_pending = 1'b1;
                end
            end else if (flush_if_id || flush_id_ex) begin
                check("spurious_flush", 32'({flush_if_id, flush_id_ex}), 32'd0);
            end
        end
    end

    task automatic do_eret(input string tag, input logic [31:0] ret_pc);
        push(ret_pc, 1'b0, ret_pc, 2'b00, 1'b0);
        eret = 1'b1;
        wait_redirect(tag, 1);
        eret = 1'b0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; irq = 1'b0; exc_req = 1'b0; eret = 1'b0;
        id_valid = 1'b0; stall_in = 1'b0; id_pc = '0;
`ifdef IRQ_MASK_EN
        irq_mask = 1'b0;
`endif
        step(3);
        check_all_zero("reset");
        reset = 1'b0;
        step(6);

        // IRQ basic: two sync stages plus one edge into TAKE.
        id_valid = 1'b1; id_pc = 32'h0040_0020;
        push(IRQ_VEC, 1'b1, 32'h0040_0020, 2'b01, 1'b1);
        irq = 1'b1;
        wait_redirect("irq_basic", 3);
        irq = 1'b0;
        step(1);
        do_eret("irq_basic_eret", 32'h0040_0020);

        // Stall deferral: held in WAIT while stalled.
        stall_in = 1'b1; id_pc = 32'h0040_0100;
        irq = 1'b1;
        step(6);
        irq = 1'b0;
        stall_in = 1'b0; id_pc = 32'h0040_0104;
        push(IRQ_VEC, 1'b1, 32'h0040_0104, 2'b01, 1'b1);
        wait_redirect("stall_defer", 1);
        step(1);
        do_eret("stall_eret", 32'h0040_0104);

        // Exception on the same cycle as the irq edge; irq follows after ERET.
        irq = 1'b1;
        step(2);
        exc_req = 1'b1; id_pc = 32'h0040_0200;
        push(EXC_VEC, 1'b1, 32'h0040_0200, 2'b10, 1'b1);
        wait_redirect("exc_prio", 1);
        exc_req = 1'b0; irq = 1'b0;
        step(1);
        push(32'h0040_0200, 1'b0, 32'h0040_0200, 2'b00, 1'b0);
        push(IRQ_VEC, 1'b1, 32'h0040_0300, 2'b01, 1'b1);
        eret = 1'b1; id_pc = 32'h0040_0300;
        wait_redirect("exc_eret", 1);
        eret = 1'b0;
        wait_redirect("pending_irq", 2);
        step(1);
        do_eret("pending_eret", 32'h0040_0300);

        // Kernel exception sets sticky flag, kernel irq not nested, reset clears everything.
        exc_req = 1'b1; id_pc = 32'h0040_0400;
        push(EXC_VEC, 1'b1, 32'h0040_0400, 2'b10, 1'b1);
        wait_redirect("exc_kernel_entry", 1);
        exc_req = 1'b0;
        step(1);
        exc_req = 1'b1;
        step(1);
        exc_req = 1'b0;
        check("sticky_set", 32'(err_sticky), 32'd1);
        check("kmode_in_kernel", 32'(kmode), 32'd1);
        irq = 1'b1;
        step(6);
        irq = 1'b0;
        step(2);
        check("sticky_hold", 32'(err_sticky), 32'd1);
        reset = 1'b1;
        step(1);
        check_all_zero("mid_reset");
        reset = 1'b0;
        step(10);

        // ERET outside kernel is ignored.
        eret = 1'b1;
        step(4);
        eret = 1'b0;
        check("eret_ignored_kmode", 32'(kmode), 32'd0);

`ifdef IRQ_MASK_EN
        irq_mask = 1'b1; id_pc = 32'h0040_0500;
        irq = 1'b1;
        step(22);
        irq = 1'b0;
        push(IRQ_VEC, 1'b1, 32'h0040_0500, 2'b01, 1'b1);
        irq_mask = 1'b0;
        wait_redirect("mask_drop", 1);
        step(1);
        do_eret("mask_eret", 32'h0040_0500);
`endif

        step(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_exc_ctrl.md
Name: irq_exc_ctrl

Overview:
Sequences pipeline redirection for external interrupts and ID-stage exceptions in the 5-stage MIPS pipeline.
- Synchronises and edge-detects irq, then waits for a safe ID-stage slot (valid, not stalled by the hazard unit).
- Flushes IF/ID and ID/EX, saves EPC, and redirects PC to the handler vector.
- On ERET, flushes again and redirects PC back to EPC.
- Its flush outputs are ORed with the hazard unit's clears at the pipeline registers.

Parameters:
IRQ_VECTOR, 32'h80000004, handler PC for interrupts
EXC_VECTOR, 32'h80000008, handler PC for exceptions
SYNC_STAGES, 2, irq synchroniser depth (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq  in  1  external interrupt, asynchronous level
exc_req  in  1  ID instruction undefined/illegal (valid only with id_valid)
eret  in  1  ID instruction decodes as ERET
id_pc  in  32  PC of instruction in ID
id_valid  in  1  ID holds a real (non-bubble) instruction
stall_in  in  1  hazard unit load-use/branch stall active this cycle
pc_redirect  out  1  force next PC = pc_target
pc_target  out  32  redirect address
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  clear ID/EX
epc  out  32  saved return PC
cause  out  2  00 none, 01 irq, 10 exc
kmode  out  1  handler active
err_sticky  out  1  exception raised while kmode

Behaviour:
- Reset values: all outputs 0; state IDLE; irq_pending 0.
- Synchroniser: irq passes through SYNC_STAGES flops; a rising edge of the synced signal sets irq_pending.
  - irq_pending stays set until taken.
  - An edge arriving while irq_pending is already set is absorbed (no counting).
- FSM states: IDLE, WAIT, TAKE, KERNEL, RETURN.
- IDLE: exc_req & id_valid has priority over irq_pending. A selected event goes to TAKE only if stall_in=0; otherwise it goes to WAIT.
- WAIT: re-evaluates every cycle with the same priority and moves to TAKE once id_valid=1 & stall_in=0.
- TAKE (exactly 1 cycle):
  - Asserts pc_redirect, flush_if_id, flush_id_ex.
  - pc_target = IRQ_VECTOR or EXC_VECTOR.
  - Registers epc <= id_pc and cause <= 01 or 10.
  - Clears irq_pending if the taken event was irq.
  - Next state KERNEL; kmode=1 from the next cycle.
- KERNEL:
  - irq edges still set irq_pending but are not taken (no nesting).
  - exc_req & id_valid sets err_sticky; no redirect.
  - eret & id_valid & !stall_in goes to RETURN.
- RETURN (1 cycle):
  - Asserts pc_redirect and flush_if_id; pc_target = epc; flush_id_ex = 0, because ERET itself retires harmlessly.
  - Next state IDLE with kmode=0, cause=00.
  - If irq_pending is set, it is taken normally from IDLE; minimum 1 IDLE cycle before the next TAKE.
- eret outside KERNEL: ignored.
- Outputs pc_redirect/flush_*/pc_target are combinational from state. epc/cause/kmode/err_sticky are registered.
- Same-cycle exc_req and irq edge: exception is taken, irq remains pending.
- Reset mid-operation (any state): returns to IDLE next edge; pending and sticky flags clear; epc clears to 0.
- err_sticky clears only on reset.

Optional Feature:
IRQ_MASK_EN:
- Defined: adds input irq_mask (1 bit). While irq_mask=1, pending irq is not selected in IDLE/WAIT (exceptions unaffected); pending is retained and taken when the mask drops.
- Undefined: no port; irq is never masked.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, TAKE, KERNEL, RETURN);
  - cause codes CAUSE_NONE/IRQ/EXC;
  - default vector constants.
- Sub-module irq_sync: SYNC_STAGES-flop synchroniser plus rising-edge pulse output, reset synchronously.

Test Plan:
- IRQ basic: with SYNC_STAGES=2, raise irq at cycle 10, id_valid=1, stall_in=0. Required:
  - TAKE in cycle 13: pc_redirect=1, pc_target=32'h80000004, both flushes=1;
  - cycle 14: epc=id_pc (e.g. 32'h00400020), cause=01, kmode=1.
- Stall deferral: irq pending while stall_in=1 for 3 cycles -> remains in WAIT; TAKE occurs the first cycle stall_in=0; epc = id_pc of that cycle.
- Exception priority: exc_req=1, id_valid=1 in the same cycle the irq edge is detected. Required:
  - pc_target=32'h80000008, cause=10;
  - after ERET returns, irq is taken at the first IDLE->TAKE opportunity.
- ERET: in KERNEL, eret=1, id_valid=1 -> one cycle with pc_redirect=1, pc_target=epc, flush_if_id=1, flush_id_ex=0; then kmode=0, cause=00.
- Kernel exception and reset: exc_req in KERNEL -> err_sticky=1, no redirect; synchronous reset in KERNEL -> next cycle all outputs 0, state IDLE.
- IRQ_MASK_EN build: irq_mask=1 with irq edge -> no TAKE for 20 cycles; drop mask -> TAKE in the next eligible cycle.
